mem_bus_arbiter: RTL and testbench

Shares the single CPU memory port between three requesters: the instruction fetcher (0), the execute unit's load/store path (1), and the stack/interrupt unit (2).
- Grants at most one access per phi1 cycle.
- Arbitration is round-robin, with a per-requester bounded lock for multi-byte bursts such as operand or vector fetches.
- Honours the 6502 RDY line.
- Sits between the requesters and the memory/selector mux.

---
 rtl/mem_bus_arbiter_pkg.sv | 41 ++++
 rtl/mem_bus_arbiter_if.sv | 32 +++
 rtl/mem_bus_arbiter_rr_pick3.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the CPU memory-port arbiter.
// Width defaults apply only when the surrounding core has not already defined them.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package mem_bus_arbiter_pkg;

  localparam int REG_WIDTH  = `REG_WIDTH;
  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int NUM_REQ    = 3;

  localparam logic [1:0] REQ_FETCH  = 2'd0;
  localparam logic [1:0] REQ_EXEC   = 2'd1;
  localparam logic [1:0] REQ_STACK  = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_LOCKED = 2'd2,
    ARB_HOLD   = 2'd3
  } arb_state_t;

  // Modulo-3 successor; any out-of-range pointer wraps to requester 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side bus of the arbiter; master = CPU units and memory,
// slave = the arbiter itself.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic                          rdy;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*REG_WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [REG_WIDTH-1:0]          rdata;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [REG_WIDTH-1:0]          mem_wdata;
  logic [REG_WIDTH-1:0]          mem_rdata;
  logic [1:0]                    owner;

  modport master (
    output rdy, req, lock, we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
  );

  modport slave (
    input  rdy, req, lock, we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, owner
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: first eligible requester
// starting at ptr, skipping any requester flagged in exclude.
module rr_pick3
  import mem_bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] probe;
  logic [1:0]         idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    eligible = req & ~exclude;
    gnt      = '0;
    idx      = (ptr > 2'd2) ? 2'd0 : ptr;
    probe    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = 3'b001 << idx;
      if (gnt == '0 && (eligible & probe) != '0) gnt = probe;
      idx = next_ptr(idx);
    end
    valid = |gnt;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the CPU memory port between fetch, execute and stack units: round-robin
// with bounded per-owner burst locks, stalled by the 6502 RDY line.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic             phi1,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t         state;
  logic [1:0]         rr_ptr;
  logic [1:0]         owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic               hold_locked;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_req;
  logic               owner_lock;
  logic               others_req;
  logic               apply_locked;
  logic               at_max;
  logic               keep_owner;
  logic [NUM_REQ-1:0] rr_exclude;
  logic [NUM_REQ-1:0] rr_gnt;
  logic               rr_valid;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any;
  logic [NUM_REQ-1:0] gnt_c;
  logic [1:0]         win_idx;
  logic               win_we;
  logic               win_lock;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [REG_WIDTH-1:0]  win_wdata;

  assign owner_oh   = (owner == OWNER_NONE) ? 3'b000 : (3'b001 << owner);
  assign owner_req  = |(bus.req & owner_oh);
  assign owner_lock = |(bus.lock & owner_oh);
  assign others_req = |(bus.req & ~owner_oh);
  assign at_max     = (lock_cnt == CNT_W'(MAX_LOCK));

  // Leaving HOLD behaves like LOCKED only while the saved owner still asks.
  assign apply_locked = (state == ARB_LOCKED) ||
                        (state == ARB_HOLD && hold_locked && owner_req);
  assign keep_owner   = apply_locked && owner_req &&
                        !(owner_lock && at_max && others_req);
  assign rr_exclude   = apply_locked ? owner_oh : 3'b000;

  rr_pick3 u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .exclude (rr_exclude),
    .gnt     (rr_gnt),
    .valid   (rr_valid)
  );

  assign grant_oh  = keep_owner ? owner_oh : rr_gnt;
  assign grant_any = keep_owner || rr_valid;
  assign win_idx   = onehot_to_idx(grant_oh);
  assign gnt_c     = (bus.rdy && !reset) ? grant_oh : 3'b000;

  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        win_we    = bus.we[i];
        win_lock  = bus.lock[i];
        win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = bus.req_wdata[i*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.mem_en    = |gnt_c;
  assign bus.mem_we    = bus.mem_en && win_we;
  assign bus.mem_addr  = bus.mem_en ? win_addr  : '0;
  assign bus.mem_wdata = bus.mem_en ? win_wdata : '0;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = (|rvalid_q) ? bus.mem_rdata : '0;
  assign bus.owner     = owner;

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= 2'd0;
      owner       <= OWNER_NONE;
      lock_cnt    <= '0;
      hold_locked <= 1'b0;
      rvalid_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rvalid_q <= gnt_c & ~bus.we;
      if (!bus.rdy) begin
        if (state != ARB_HOLD) hold_locked <= (state == ARB_LOCKED);
        state <= ARB_HOLD;
      end else if (grant_any) begin
        owner       <= win_idx;
        rr_ptr      <= next_ptr(win_idx);
        hold_locked <= 1'b0;
        if (win_lock) begin
          state <= ARB_LOCKED;
          if (!keep_owner)  lock_cnt <= CNT_W'(1);
          else if (!at_max) lock_cnt <= lock_cnt + 1'b1;
        end else begin
          state    <= ARB_ACTIVE;
          lock_cnt <= '0;
        end
      end else begin
        state       <= ARB_IDLE;
        lock_cnt    <= '0;
        hold_locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-scenario tasks plus a read-response scoreboard.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int MAX_LOCK = 4;

  logic phi1;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .phi1  (phi1),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: fixed pattern, one known byte at 16'h8000, plus the last write.
  logic        have_w = 1'b0;
  logic [15:0] last_waddr = 16'h0000;
  logic [7:0]  last_wdata = 8'h00;

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] lookup(input logic [15:0] a);
    if (have_w && a == last_waddr) return last_wdata;
    if (a == 16'h8000) return 8'hA9;
    return pattern(a);
  endfunction

  always @(posedge phi1) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= lookup(bus.mem_addr);
    if (bus.mem_en && bus.mem_we) begin
      have_w     <= 1'b1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
  end

  typedef struct packed {
    logic [2:0] who;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  rd_exp_t sb_head;

  always @(negedge phi1) begin
    if (!reset && bus.rvalid !== 3'b000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got rvalid=%b rdata=%h, no read outstanding", bus.rvalid, bus.rdata);
      end else begin
        sb_head = sb_q.pop_front();
        if (bus.rvalid !== sb_head.who || bus.rdata !== sb_head.data) begin
          errors++;
          $display("FAIL read_response got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                   bus.rvalid, bus.rdata, sb_head.who, sb_head.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge phi1);
  endtask

  task automatic idle_inputs();
    bus.rdy  = 1'b1;
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    bus.we   = 3'b000;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [7:0] d);
    bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    bus.req_wdata[i*REG_WIDTH +: REG_WIDTH]  = d;
  endtask

  task automatic exp_read(input logic [2:0] who, input logic [7:0] data);
    sb_q.push_back('{who: who, data: data});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.req = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, 16'hBEEF, 8'h77);
    tick();
    #1;
    checks++;
    if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant got gnt=%b en=%b we=%b exp 000/0/0", bus.gnt, bus.mem_en, bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h exp 0000/00", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.rvalid !== 3'b000 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_read got rvalid=%b rdata=%h exp 000/00", bus.rvalid, bus.rdata);
    end
    checks++;
    if (bus.owner !== OWNER_NONE) begin
      errors++;
      $display("FAIL reset_owner got %b exp %b", bus.owner, OWNER_NONE);
    end
    tick();
    reset = 1'b0;
    bus.req = 3'b000;
  endtask

  task automatic test_reset_mid_read();
    tick();
    set_req(0, 16'h8000, 8'h00);
    bus.req = 3'b001;
    #1;
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL midread_first_gnt got %b exp 001", bus.gnt);
    end
    exp_read(3'b001, 8'hA9);
    tick();
    #1;
    checks++;
    if (bus.gnt !== 3'b001 || bus.owner !== REQ_FETCH || bus.mem_addr !== 16'h8000) begin
      errors++;
      $display("FAIL midread_inflight got gnt=%b owner=%b addr=%h exp 001/00/8000",
               bus.gnt, bus.owner, bus.mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0 || bus.owner !== OWNER_NONE) begin
      errors++;
      $display("FAIL midread_reset_now got gnt=%b en=%b owner=%b exp 000/0/11",
               bus.gnt, bus.mem_en, bus.owner);
    end
    tick();
    reset = 1'b0;
    bus.req = 3'b000;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.rvalid !== 3'b000) begin
        errors++;
        $display("FAIL midread_dropped cycle %0d got rvalid=%b exp 000", c, bus.rvalid);
      end
      tick();
    end
  endtask

  task automatic test_fetch_read();
    set_req(0, 16'h8000, 8'h00);
    bus.req = 3'b001;
    bus.we  = 3'b000;
    #1;
    checks++;
    if (bus.gnt !== 3'b001 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h8000) begin
      errors++;
      $display("FAIL fetch_grant got gnt=%b en=%b we=%b addr=%h exp 001/1/0/8000",
               bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    exp_read(3'b001, 8'hA9);
    tick();
    bus.req = 3'b000;
    #1;
    checks++;
    if (bus.rvalid !== 3'b001 || bus.rdata !== 8'hA9) begin
      errors++;
      $display("FAIL fetch_data got rvalid=%b rdata=%h exp 001/a9", bus.rvalid, bus.rdata);
    end
    tick();
    #1;
    checks++;
    if (bus.rvalid !== 3'b000 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL fetch_idle got rvalid=%b rdata=%h exp 000/00", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] addr [3];
    logic [2:0]  exp_gnt;
    int          w;
    addr = '{16'h1200, 16'h2340, 16'h3460};
    apply_reset();
    for (int i = 0; i < 3; i++) set_req(i, addr[i], 8'h00);
    bus.req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      w = c % 3;
      exp_gnt = 3'b001 << w;
      #1;
      checks++;
      if (bus.gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_grant cycle %0d got %b exp %b", c, bus.gnt, exp_gnt);
      end
      checks++;
      if (bus.mem_addr !== addr[w]) begin
        errors++;
        $display("FAIL rr_addr cycle %0d got %h exp %h", c, bus.mem_addr, addr[w]);
      end
      exp_read(exp_gnt, pattern(addr[w]));
      tick();
    end
    bus.req = 3'b000;
    tick();
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_idx [6];
    logic [1:0] exp_own [6];
    logic [2:0] exp_gnt;
    exp_idx = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
    exp_own = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    apply_reset();
    set_req(0, 16'h4000, 8'h00);
    set_req(1, 16'h5000, 8'h00);
    set_req(2, 16'h6000, 8'h00);
    bus.req = 3'b001;
    #1;
    checks++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL lock_setup got %b exp 001", bus.gnt);
    end
    exp_read(3'b001, pattern(16'h4000));
    tick();
    bus.req  = 3'b111;
    bus.lock = 3'b010;
    for (int c = 0; c < 6; c++) begin
      exp_gnt = 3'b001 << exp_idx[c];
      #1;
      checks++;
      if (bus.gnt !== exp_gnt || bus.owner !== exp_own[c]) begin
        errors++;
        $display("FAIL lock_burst cycle %0d got gnt=%b owner=%0d exp gnt=%b owner=%0d",
                 c, bus.gnt, bus.owner, exp_gnt, exp_own[c]);
      end
      exp_read(exp_gnt, pattern(16'h4000 + 16'h1000 * exp_idx[c]));
      tick();
    end
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    tick();
  endtask

  task automatic test_rdy_hold();
    logic [2:0] resume [3];
    resume = '{3'b100, 3'b100, 3'b001};
    apply_reset();
    set_req(REQ_STACK, 16'h01FD, 8'h00);
    set_req(REQ_FETCH, 16'h8001, 8'h00);
    bus.req  = 3'b100;
    bus.lock = 3'b100;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.gnt !== 3'b100) begin
        errors++;
        $display("FAIL hold_burst cycle %0d got %b exp 100", c, bus.gnt);
      end
      exp_read(3'b100, pattern(16'h01FD));
      tick();
    end
    bus.rdy = 1'b0;
    bus.req = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.gnt !== 3'b000 || bus.mem_en !== 1'b0 || bus.owner !== REQ_STACK) begin
        errors++;
        $display("FAIL hold_stall cycle %0d got gnt=%b en=%b owner=%0d exp 000/0/2",
                 c, bus.gnt, bus.mem_en, bus.owner);
      end
      if (c == 0) begin
        checks++;
        if (bus.rvalid !== 3'b100) begin
          errors++;
          $display("FAIL hold_pending_rvalid got %b exp 100", bus.rvalid);
        end
      end
      tick();
    end
    bus.rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.gnt !== resume[c]) begin
        errors++;
        $display("FAIL hold_resume cycle %0d got %b exp %b", c, bus.gnt, resume[c]);
      end
      exp_read(resume[c], (resume[c] == 3'b100) ? pattern(16'h01FD) : pattern(16'h8001));
      tick();
    end
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    tick();
  endtask

  task automatic test_exec_write();
    set_req(REQ_EXEC, 16'h0200, 8'h5A);
    bus.req = 3'b010;
    bus.we  = 3'b010;
    #1;
    checks++;
    if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL write_bus got gnt=%b we=%b addr=%h wdata=%h exp 010/1/0200/5a",
               bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.req = 3'b000;
    bus.we  = 3'b000;
    #1;
    checks++;
    if (bus.rvalid !== 3'b000) begin
      errors++;
      $display("FAIL write_no_rvalid got %b exp 000", bus.rvalid);
    end
    tick();
    bus.req = 3'b010;
    #1;
    checks++;
    if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_readback_grant got gnt=%b we=%b exp 010/0", bus.gnt, bus.mem_we);
    end
    exp_read(3'b010, 8'h5A);
    tick();
    bus.req = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back();
    // rr_ptr is 2 here: the fetch read wins first, the exec write waits a cycle.
    set_req(REQ_FETCH, 16'h4444, 8'h00);
    set_req(REQ_EXEC, 16'h0300, 8'hC3);
    bus.req = 3'b011;
    bus.we  = 3'b010;
    #1;
    checks++;
    if (bus.gnt !== 3'b001 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h4444) begin
      errors++;
      $display("FAIL b2b_read got gnt=%b we=%b addr=%h exp 001/0/4444", bus.gnt, bus.mem_we, bus.mem_addr);
    end
    exp_read(3'b001, pattern(16'h4444));
    tick();
    bus.req = 3'b010;
    #1;
    checks++;
    if (bus.gnt !== 3'b010 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_write got gnt=%b we=%b wdata=%h exp 010/1/c3", bus.gnt, bus.mem_we, bus.mem_wdata);
    end
    tick();
    bus.req = 3'b000;
    bus.we  = 3'b000;
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_fetch_read();
    test_round_robin();
    test_lock_burst();
    test_rdy_hold();
    test_exec_write();
    test_back_to_back();
    tick();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d reads outstanding exp 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
